// File: rtl/buyruk_getir_onbellek.sv
// buyruk_getir_onbellek - instruction-fetch front end.
// Drives port A of the instruction SRAM (1-cycle read latency), tags each
// read with its byte PC and queues {pc, instruction} pairs in a small FIFO
// towards decode (valid/ready). A redirect flushes the FIFO, drops the
// response arriving in that cycle and fetches the target immediately.
// Optional build macro: YUKLEYICI_EN adds a program-load write port.

module buyruk_getir_onbellek #(
    parameter int unsigned ADRES_BIT = 10,
    parameter int unsigned DERINLIK  = 2,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADRES_BIT-1:0] bb_addra_o,
    output logic                 bb_ena_o,
    output logic [3:0]           bb_wea_o,
    output logic [31:0]          bb_dina_o,
    input  logic [31:0]          bb_douta_i,
    output logic [31:0]          buyruk_o,
    output logic [31:0]          pc_o,
    output logic                 gecerli_o,
    input  logic                 hazir_i,
    input  logic                 dallan_i,
    input  logic [31:0]          dallan_adres_i
`ifdef YUKLEYICI_EN
    ,
    input  logic                 yukle_i,
    input  logic [ADRES_BIT-1:0] yukle_adres_i,
    input  logic [31:0]          yukle_veri_i
`endif
);

    localparam int unsigned PW = $clog2(DERINLIK);
    localparam int unsigned CW = $clog2(DERINLIK + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] buyruk;
    } giris_t;

    // FIFO storage and pointers
    giris_t        fifo_q [DERINLIK];
    logic [PW-1:0] bas_q, bas_d;
    logic [PW-1:0] kuyruk_q, kuyruk_d;
    logic [CW-1:0] sayac_q, sayac_d;

    // Fetch state
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   etiket_q, etiket_d;   // byte PC of the read in flight
    logic          ucusta_q, ucusta_d;   // a read response arrives this cycle
    logic          calisiyor_q;          // first edge after reset has passed

    // Per-cycle decisions
    logic          pop;
    logic          push;
    logic          yer_var;
    logic          okuma;
    logic          yukle;
    logic [31:0]   hedef;
    logic [31:0]   okuma_pc;

    // Load cycles only happen once the front end is running, so the SRAM port
    // stays completely idle straight out of reset.
`ifdef YUKLEYICI_EN
    assign yukle = calisiyor_q & yukle_i;
`else
    assign yukle = 1'b0;
`endif

    assign hedef     = {dallan_adres_i[31:2], 2'b00};
    assign gecerli_o = (sayac_q != '0);
    assign buyruk_o  = fifo_q[bas_q].buyruk;
    assign pc_o      = fifo_q[bas_q].pc;
    assign pop       = gecerli_o & hazir_i;
    // The response landing in a redirect cycle belongs to the old stream.
    assign push      = ucusta_q & ~dallan_i;

    // Entries already held plus the one in flight must leave a slot for the
    // new read, counting the slot freed by this cycle's pop.
    assign yer_var = (32'(sayac_q) + 32'(ucusta_q)) < (DERINLIK + 32'(pop));

    // After a flush the FIFO is empty, so the target can always be issued.
    assign okuma    = calisiyor_q & ~yukle & (dallan_i | yer_var);
    assign okuma_pc = dallan_i ? hedef : pc_q;

    // SRAM port A drive: read of the fetch PC, or a full-word program load.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        bb_ena_o   = okuma;
        bb_wea_o   = 4'h0;
        bb_dina_o  = 32'h0;
        bb_addra_o = okuma_pc[ADRES_BIT+1:2];
`ifdef YUKLEYICI_EN
        if (yukle) begin
            bb_ena_o   = 1'b1;
            bb_wea_o   = 4'hF;
            bb_addra_o = yukle_adres_i;
            bb_dina_o  = yukle_veri_i;
        end
`endif
    end

    // Next PC, in-flight tag and FIFO pointer/count updates.
    always_comb begin
        pc_d     = pc_q;
        etiket_d = etiket_q;
        ucusta_d = okuma;
        bas_d    = bas_q;
        kuyruk_d = kuyruk_q;
        sayac_d  = sayac_q;

        if (dallan_i) begin
            // Target is either fetched now, or held until the next non-load cycle.
            pc_d = okuma ? (hedef + 32'd4) : hedef;
        end else if (okuma) begin
            pc_d = pc_q + 32'd4;
        end

        if (okuma) begin
            etiket_d = okuma_pc;
        end

        if (dallan_i) begin
            bas_d    = '0;
            kuyruk_d = '0;
            sayac_d  = '0;
        end else begin
            if (push) begin
                kuyruk_d = kuyruk_q + 1'b1;
            end
            if (pop) begin
                bas_d = bas_q + 1'b1;
            end
            sayac_d = sayac_q + CW'(push) - CW'(pop);
        end
    end

    // Fetch and FIFO control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before the edge, independent of statement order.
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            etiket_q    <= 32'h0;
            ucusta_q    <= 1'b0;
            calisiyor_q <= 1'b0;
            bas_q       <= '0;
            kuyruk_q    <= '0;
            sayac_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            etiket_q    <= etiket_d;
            ucusta_q    <= ucusta_d;
            calisiyor_q <= 1'b1;
            bas_q       <= bas_d;
            kuyruk_q    <= kuyruk_d;
            sayac_q     <= sayac_d;
        end
    end

    // FIFO entry storage: the captured SRAM word together with its tag.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the entries are reset because the head drives buyruk_o/pc_o
        // directly and those must read zero out of reset; storage that is never
        // observed before being written would not need this.
        if (!rst_n) begin
            for (int i = 0; i < DERINLIK; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[kuyruk_q] <= '{pc: etiket_q, buyruk: bb_douta_i};
        end
    end

endmodule
